// File: rtl/pla_pkg.sv
// Shared types and defaults for the PLA response MISR compactor.
// Contents: response width, FSM state enum, default MISR polynomial and seed.
package pla_pkg;

  localparam int unsigned RESP_W = 10;

  localparam logic [15:0] POLY_DEFAULT = 16'h1021;
  localparam logic [15:0] SEED_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/pla_misr_step.sv
// One MISR compaction step: shift left, fold in polynomial when the MSB
// falls out, then XOR in the zero-extended PLA response.
// Ports:
//   sig        current signature
//   resp       PLA output vector z9..z0
//   next_sig_c next signature (combinational)
module pla_misr_step
  import pla_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT)
) (
  input  logic [SIG_W-1:0]  sig,
  input  logic [RESP_W-1:0] resp,
  output logic [SIG_W-1:0]  next_sig_c
);

  logic [SIG_W-1:0] fb;

  assign fb         = sig[SIG_W-1] ? POLY : '0;
  assign next_sig_c = {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(resp);

endmodule

// File: rtl/pla_resp_misr.sv
// PLA response compactor: accumulates a run of 10-bit response beats into a
// MISR signature, counts beats (saturating) and keeps a sticky OR of all
// accepted responses. The result is held until the consumer takes it.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             opens a run (only honoured in IDLE)
//   in_valid/in_ready response beat handshake; in_ready only in ACCUM
//   in_resp, in_last  response vector, final-beat marker
//   sig_out           signature
//   sig_valid/sig_ready result handshake
//   vec_count         beats accepted in current/last run
//   ever_hi           sticky OR of accepted responses
//   busy              state is not IDLE
module pla_resp_misr
  import pla_pkg::*;
#(
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(POLY_DEFAULT),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(SEED_DEFAULT),
  parameter int unsigned      CNT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [RESP_W-1:0] in_resp,
  input  logic              in_last,
  output logic [SIG_W-1:0]  sig_out,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [CNT_W-1:0]  vec_count,
  output logic [RESP_W-1:0] ever_hi,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [SIG_W-1:0]  sig_q, sig_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RESP_W-1:0] ev_q, ev_d;
  logic              valid_q, valid_d;
  logic [SIG_W-1:0]  step_sig_c;
  logic              accept_c;

  pla_misr_step #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_step (
    .sig        (sig_q),
    .resp       (in_resp),
    .next_sig_c (step_sig_c)
  );

  // Handshake-side decodes straight from state
  assign in_ready = (state_q == ACCUM);
  assign busy     = (state_q != IDLE);
  assign accept_c = in_valid && in_ready;

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    ev_d    = ev_q;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          sig_d   = SEED;
          cnt_d   = '0;
          ev_d    = '0;
        end
      end
      ACCUM: begin
        if (accept_c) begin
          sig_d = step_sig_c;
          // Saturate rather than wrap so long runs stay recognisable
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          ev_d  = ev_q | in_resp;
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        // start is deliberately not looked at here
        if (sig_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    valid_d = (state_d == HOLD);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      ev_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      ev_q    <= ev_d;
      valid_q <= valid_d;
    end
  end

  assign sig_out   = sig_q;
  assign vec_count = cnt_q;
  assign ever_hi   = ev_q;
  assign sig_valid = valid_q;

endmodule

// File: tb/tb_pla_resp_misr.sv
// Randomised self-checking bench for pla_resp_misr. Two instances share the
// inputs: the default one and one with a 2-bit beat counter.
module tb_pla_resp_misr;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_last, sig_ready;
  logic [9:0] in_resp;

  logic        in_ready, sig_valid, busy;
  logic [15:0] sig_out;
  logic [19:0] vec_count;
  logic [9:0]  ever_hi;

  logic        in_ready2, sig_valid2, busy2;
  logic [15:0] sig_out2;
  logic [1:0]  vec_count2;
  logic [9:0]  ever_hi2;

  int total = 0;
  int bad   = 0;

  // Reference model: run mode 0=idle 1=collecting 2=waiting for consumer
  int          m_mode;
  logic [15:0] m_sig;
  int          m_cnt;
  logic [9:0]  m_ev;

  always #5 clk = ~clk;

  pla_resp_misr dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_resp(in_resp), .in_last(in_last),
    .sig_out(sig_out), .sig_valid(sig_valid), .sig_ready(sig_ready),
    .vec_count(vec_count), .ever_hi(ever_hi), .busy(busy)
  );

  pla_resp_misr #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready2), .in_resp(in_resp), .in_last(in_last),
    .sig_out(sig_out2), .sig_valid(sig_valid2), .sig_ready(sig_ready),
    .vec_count(vec_count2), .ever_hi(ever_hi2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Signature as polynomial arithmetic: multiply by x mod p(x), add response
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [9:0] r);
    int unsigned v;
    v = 32'(s) * 2;
    if (v >= 32'h1_0000) v = (v - 32'h1_0000) ^ 32'h1021;
    return 16'(v) ^ {6'd0, r};
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_mode = 0; m_sig = 16'hFFFF; m_cnt = 0; m_ev = '0;
    end else if (m_mode == 0) begin
      if (start) begin m_mode = 1; m_sig = 16'hFFFF; m_cnt = 0; m_ev = '0; end
    end else if (m_mode == 1) begin
      if (in_valid) begin
        m_sig = misr(m_sig, in_resp);
        m_cnt++;
        m_ev  = m_ev | in_resp;
        if (in_last) m_mode = 2;
      end
    end else begin
      if (sig_ready) m_mode = 0;
    end
  endtask

  task automatic check_all();
    int sat20;
    sat20 = (m_cnt > 32'hF_FFFF) ? 32'hF_FFFF : m_cnt;
    check("sig_out",    32'(sig_out),    32'(m_sig));
    check("vec_count",  32'(vec_count),  32'(sat20));
    check("ever_hi",    32'(ever_hi),    32'(m_ev));
    check("sig_valid",  32'(sig_valid),  32'(m_mode == 2));
    check("in_ready",   32'(in_ready),   32'(m_mode == 1));
    check("busy",       32'(busy),       32'(m_mode != 0));
    check("sig_out2",   32'(sig_out2),   32'(m_sig));
    check("vec_count2", 32'(vec_count2), 32'((m_cnt > 3) ? 3 : m_cnt));
    check("sig_valid2", 32'(sig_valid2), 32'(m_mode == 2));
  endtask

  task automatic step(input logic r, input logic st, input logic v, input logic [9:0] resp,
                      input logic l, input logic rdy);
    rst = r; start = st; in_valid = v; in_resp = resp; in_last = l; sig_ready = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    m_mode = 0; m_sig = 16'hFFFF; m_cnt = 0; m_ev = '0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_resp = '0; in_last = 1'b0; sig_ready = 1'b0;

    // Reset, single zero beat, consumer always ready
    step(1, 0, 0, 10'h000, 0, 1);
    step(1, 0, 0, 10'h000, 0, 1);
    check("rst_sig", 32'(sig_out), 32'hFFFF);
    step(0, 1, 0, 10'h000, 0, 1);
    step(0, 0, 1, 10'h000, 1, 1);
    check("s1_sig", 32'(sig_out), 32'hEFDF);
    check("s1_cnt", 32'(vec_count), 32'd1);
    check("s1_valid", 32'(sig_valid), 32'd1);
    step(0, 0, 0, 10'h000, 0, 1);
    check("s1_valid_drop", 32'(sig_valid), 32'd0);

    // All-ones single beat
    step(0, 1, 0, 10'h000, 0, 0);
    step(0, 0, 1, 10'h3FF, 1, 0);
    check("s2_sig", 32'(sig_out), 32'hEC20);
    check("s2_ev", 32'(ever_hi), 32'h3FF);
    step(0, 0, 0, 10'h000, 0, 1);

    // Two zero beats with a bubble
    step(0, 1, 0, 10'h000, 0, 0);
    step(0, 0, 1, 10'h000, 0, 0);
    step(0, 0, 0, 10'h155, 1, 0);
    step(0, 0, 1, 10'h000, 1, 0);
    check("s3_sig", 32'(sig_out), 32'hCF9F);
    check("s3_cnt", 32'(vec_count), 32'd2);

    // Consumer stalls 5 cycles, then start arrives with ready
    for (int i = 0; i < 5; i++) step(0, 0, 1, 10'h2AA, 1, 0);
    check("s4_frozen", 32'(sig_out), 32'hCF9F);
    step(0, 1, 0, 10'h000, 0, 1);
    check("s4_idle", 32'(busy), 32'd0);
    step(0, 0, 0, 10'h000, 0, 0);
    check("s4_no_start", 32'(busy), 32'd0);

    // Reset mid-run after 3 beats
    step(0, 1, 0, 10'h000, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 10'(i + 1), 0, 0);
    step(1, 0, 1, 10'h001, 1, 1);
    check("s5_sig", 32'(sig_out), 32'hFFFF);
    check("s5_cnt", 32'(vec_count), 32'd0);

    // Five beats: small counter saturates, signature still full
    step(0, 1, 0, 10'h000, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 10'(i * 37), (i == 4), 0);
    check("s6_cnt2", 32'(vec_count2), 32'd3);
    check("s6_cnt", 32'(vec_count), 32'd5);
    step(0, 0, 0, 10'h000, 0, 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0),
           10'($urandom),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pla_resp_misr.md
PLA_RESP_MISR -- requirements
Module: pla_resp_misr

Interface
REQ-001 The block SHALL have parameter SIG_W, default 16, giving the signature width.
REQ-002 The block SHALL have parameter POLY, default 16'h1021, giving the MISR feedback taps.
REQ-003 The block SHALL have parameter SEED, default 16'hFFFF, giving the signature value loaded on start.
REQ-004 The block SHALL have parameter CNT_W, default 20, giving the beat-counter width.
REQ-005 The block SHALL have a single clock and a synchronous active-high reset:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-006 The block SHALL have these control and data ports:
- start  in  1  one-cycle pulse that opens a compaction run.
- in_valid  in  1  response beat present.
- in_ready  out  1  block accepts a beat.
- in_resp  in  10  PLA output vector z9..z0 (bit i = zi).
- in_last  in  1  final beat of the run; qualified by in_valid.
REQ-007 The block SHALL have these result ports:
- sig_out  out  SIG_W  final signature.
- sig_valid  out  1  result available.
- sig_ready  in  1  consumer takes the result.
- vec_count  out  CNT_W  beats accepted in the current or last run.
- ever_hi  out  10  sticky OR of all accepted in_resp values.
- busy  out  1  high when the state is not IDLE.

Function
REQ-008 The FSM SHALL have exactly three states, IDLE, ACCUM and HOLD.
REQ-009 In IDLE, start=1 SHALL move the FSM to ACCUM next cycle, load signature=SEED, vec_count=0 and ever_hi=0.
REQ-010 start SHALL be ignored in ACCUM and HOLD.
REQ-011 in_ready SHALL equal 1 only in ACCUM, decoded combinationally from state.
REQ-012 A beat SHALL be accepted only when in_valid and in_ready are both 1; beats presented in IDLE or HOLD SHALL have no effect.
REQ-013 On each accepted beat, next signature SHALL be ({sig[SIG_W-2:0],1'b0} XOR (sig[SIG_W-1] ? POLY : 0) XOR zero-extended in_resp).
REQ-014 The signature update SHALL appear in sig_out the following cycle (one-cycle latency).
REQ-015 On each accepted beat, vec_count SHALL increment by 1 and saturate at all-ones; it SHALL never wrap.
REQ-016 On each accepted beat, ever_hi SHALL become ever_hi OR in_resp.
REQ-017 An accepted beat with in_last=1 SHALL be included in the signature and SHALL move the FSM to HOLD, with sig_valid=1 from the next cycle.
REQ-018 In HOLD, sig_out, vec_count and ever_hi SHALL be frozen and sig_valid SHALL stay 1 until sig_ready=1.
REQ-019 In HOLD, sig_ready=1 SHALL return the FSM to IDLE next cycle, with sig_valid=0 from that cycle.
REQ-020 In HOLD, start=1 together with sig_ready=1 SHALL complete the handshake and go to IDLE; start SHALL NOT be taken that cycle.
REQ-021 In IDLE, sig_out, vec_count and ever_hi SHALL keep their last values until the next start.
REQ-022 sig_ready SHALL be ignored outside HOLD.
REQ-023 in_last without in_valid SHALL be ignored.

Reset
REQ-024 rst SHALL force, on the next edge: state=IDLE, sig_out=SEED, vec_count=0, ever_hi=0, sig_valid=0, in_ready=0, busy=0.
REQ-025 rst SHALL take priority over start, beat acceptance and sig_ready in the same cycle.
REQ-026 A reset during ACCUM or HOLD SHALL abandon the run with no result produced.

Structure
REQ-027 Package pla_pkg SHALL hold the FSM state enum (IDLE, ACCUM, HOLD) and the default constants POLY_DEFAULT=16'h1021 and SEED_DEFAULT=16'hFFFF.
REQ-028 The one-beat update SHALL be a purely combinational sub-module pla_misr_step (inputs sig and resp, output next sig), instantiated once.
REQ-029 All other logic SHALL be in pla_resp_misr, and all outputs SHALL be registered except in_ready and busy, which are decoded from state.

Verification
REQ-030 Scenario: rst, start, one beat in_resp=10'h000 with in_last=1, sig_ready=1 -> sig_out=16'hEFDF, vec_count=1, ever_hi=0, sig_valid high exactly 1 cycle.
REQ-031 Scenario: start, one beat in_resp=10'h3FF with in_last=1 -> sig_out=16'hEC20, ever_hi=10'h3FF.
REQ-032 Scenario: start, two beats of 10'h000 with in_valid toggling 1,0,1 and in_last on the second beat -> sig_out=16'hCF9F, vec_count=2, and the idle cycle has no effect.
REQ-033 Scenario: hold sig_ready=0 for 5 cycles after last, then assert start and sig_ready together -> sig_valid stays 1 and outputs stay frozen for the 5 cycles, FSM returns to IDLE, and start is not taken.
REQ-034 Scenario: rst asserted mid-ACCUM after 3 beats -> next cycle sig_out=16'hFFFF, vec_count=0, busy=0, and no sig_valid.
REQ-035 Scenario: CNT_W=2, five beats, last on the fifth -> vec_count saturates at 3 and the signature still reflects all 5 beats.
